hazard_unit: RTL

- Backward-direction control for the 5-stage MIPS pipeline.
- Reads the outputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Drives stall, flush and forwarding controls back into those registers and into the EX operand muxes.
- Owns a small FSM that handles a multi-cycle data-memory handshake, with a timeout error.

---
 rtl/hazard_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage MIPS pipeline: forwarding, load-use/branch/memory stalls and flushes.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] writereg_e,
    input  logic       memtoreg_e,
    input  logic       regwrite_e,
    input  logic [4:0] writereg_m,
    input  logic       regwrite_m,
    input  logic       memaccess_m,
    input  logic       pcsrc_m,
    input  logic       dmem_ready,
    input  logic [4:0] writereg_w,
    input  logic       regwrite_w,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       flush_w,
    output logic [1:0] forward_ae,
    output logic [1:0] forward_be,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;

    logic w_mem_req_stall;
    logic w_wait_last;
    logic w_load_use;
    logic w_branch_flush;

    assign w_mem_req_stall = memaccess_m && !dmem_ready;
    assign w_wait_last     = (r_wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign w_load_use      = memtoreg_e && regwrite_e && (writereg_e != 5'd0) &&
                             ((writereg_e == rs_d) || (writereg_e == rt_d));
    assign w_branch_flush  = (r_state == S_RUN) && !w_mem_req_stall && pcsrc_m;

    // MEM stage result is younger than WB, so it wins; register 0 is hard-wired zero.
    always_comb begin
        forward_ae = 2'b00;
        forward_be = 2'b00;
        if (regwrite_m && writereg_m != 5'd0 && writereg_m == rs_e)
            forward_ae = 2'b10;
        else if (regwrite_w && writereg_w != 5'd0 && writereg_w == rs_e)
            forward_ae = 2'b01;
        if (regwrite_m && writereg_m != 5'd0 && writereg_m == rt_e)
            forward_be = 2'b10;
        else if (regwrite_w && writereg_w != 5'd0 && writereg_w == rt_e)
            forward_be = 2'b01;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN:      if (w_mem_req_stall) w_next_state = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (dmem_ready)       w_next_state = S_RUN;
                else if (w_wait_last) w_next_state = S_ERR;
            end
            S_ERR:      w_next_state = S_ERR;
            default:    w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_mem_req_stall) begin
                    {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                end else if (pcsrc_m) begin
                    {flush_d, flush_e, flush_m} = 3'b111;
                end else if (w_load_use) begin
                    {stall_f, stall_d, flush_e} = 3'b111;
                end
            end
            S_MEM_WAIT: begin
                if (!dmem_ready)
                    {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
            end
            S_ERR: begin
                {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
            end
            default: ;
        endcase
    end

    // wait_cnt counts consecutive unready cycles, including the one that left RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN:      r_wait_cnt <= w_mem_req_stall ? 8'd1 : 8'd0;
                S_MEM_WAIT: begin
                    if (dmem_ready)        r_wait_cnt <= 8'd0;
                    else if (!w_wait_last) r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                default:    r_wait_cnt <= r_wait_cnt;
            endcase
            if (w_next_state == S_ERR) r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (stall_f && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_branch_flush && r_flush_events != '1)
                r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule
